icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL provide parameter NUM_LINES, default 32: number of direct-mapped lines; power of two, 2..256.
REQ-002 SHALL provide parameter LINE_BYTES, default 32: fixed line size of 8 words, matching the 256-bit IM block bus.
REQ-003 SHALL have port CLK, input, 1: sole clock, rising edge.
REQ-004 SHALL have port RESET, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port Instr_address_2IC, input, 32: fetch address from IF, word-aligned.
REQ-006 SHALL have port Invalidate_2IC, input, 1: flush all lines; driven from SYS.
REQ-007 SHALL have port Instr1_fIC, output, 32: word at Instr_address_2IC.
REQ-008 SHALL have port Instr2_fIC, output, 32: word at Instr_address_2IC+4.
REQ-009 SHALL have port Instr1_valid_fIC, output, 1: Instr1_fIC is a hit this cycle.
REQ-010 SHALL have port Instr2_valid_fIC, output, 1: Instr2_fIC is valid this cycle.
REQ-011 SHALL have port STALL_2IF, output, 1: IF must hold PC; equals ~Instr1_valid_fIC.
REQ-012 SHALL have port Instr_address_2IM, output, 32: line-aligned fill address.
REQ-013 SHALL have port iBlkRead, output, 1: block-read request to IM.
REQ-014 SHALL have port block_read_fIM, input, 256: fill data; word k = bits [32k+31:32k], lowest address in word 0.
REQ-015 SHALL have port block_read_fIM_valid, input, 1: fill data valid this cycle.

Function
REQ-016 Address split SHALL be: offset [4:2], index [4+log2(NUM_LINES):5], tag = the remaining upper bits.
REQ-017 Storage SHALL be, per line: valid bit, tag, 256-bit data, all registered.
REQ-018 Lookup SHALL be combinational in IDLE: hit = valid[index] && tag match; Instr1_fIC = word[offset].
REQ-019 Hit latency SHALL be 0 cycles; IF advances on the same edge.
REQ-020 The FSM SHALL have two states, IDLE and FILL.
REQ-021 In IDLE on a miss, the next edge SHALL latch {addr[31:5],5'b0} into Instr_address_2IM and enter FILL.
REQ-022 In FILL, iBlkRead SHALL be 1 and Instr_address_2IM held stable until block_read_fIM_valid.
REQ-023 In FILL, the Instr1/Instr2 valid outputs SHALL be 0.
REQ-024 On FILL with block_read_fIM_valid=1, the edge SHALL write data and tag, set valid, and return to IDLE; iBlkRead drops the next cycle.
REQ-025 Miss penalty SHALL be IM latency + 2 cycles (miss detect, fill, re-lookup hit).
REQ-026 If Instr_address_2IC changes during FILL (redirect), the fill SHALL complete for the latched line; lookup of the new address occurs in IDLE.
REQ-027 Invalidate_2IC=1 SHALL clear all valid bits at the next edge.
REQ-028 Invalidate_2IC in FILL SHALL abort to IDLE without writing, even if block_read_fIM_valid=1 that cycle.
REQ-029 While Invalidate_2IC=1, Instr1_valid_fIC and Instr2_valid_fIC SHALL be 0.
REQ-030 block_read_fIM_valid in IDLE SHALL be ignored.

Reset
REQ-031 RESET=0 at an edge SHALL clear all valid bits, set state IDLE, iBlkRead=0, Instr_address_2IM=0.
REQ-032 Instr1_valid_fIC and Instr2_valid_fIC SHALL be 0 during reset; STALL_2IF=1.
REQ-033 Reset during FILL SHALL abandon the fill; no line is written.

Configuration
REQ-034 Macro ICACHE_DUAL_FETCH_EN defined: Instr2_fIC = word[offset+1]; Instr2_valid_fIC = Instr1_valid_fIC && offset != 7 (no line crossing).
REQ-035 Macro ICACHE_DUAL_FETCH_EN undefined: Instr2_fIC = 0 and Instr2_valid_fIC = 0 constantly.

Verification
REQ-036 Reset, then addr 0x00400000 -> miss; iBlkRead=1 with Instr_address_2IM=0x00400000; valid after 3 cycles -> Instr1 = block word 0, valid=1.
REQ-037 After the fill, addr 0x0040001C -> same-cycle hit returning word 7; with ICACHE_DUAL_FETCH_EN, Instr2_valid_fIC=0.
REQ-038 Conflict: fill 0x00400000, then 0x00400400 (same index for NUM_LINES=32) -> miss and refill; 0x00400000 then misses again.
REQ-039 Redirect mid-fill: miss 0x00400020, then addr changes to 0x00400040 during FILL -> line 0x00400020 written, then a second fill for 0x00400040.
REQ-040 Invalidate_2IC=1 in the same cycle as block_read_fIM_valid=1 -> no write; all lines miss afterwards.
REQ-041 RESET=0 mid-FILL -> iBlkRead=0 next cycle, state IDLE, previously filled lines miss.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, 8-word lines; ICACHE_DUAL_FETCH_EN adds a second same-line word.
// Hits return in 0 cycles; misses hold IF via STALL_2IF until the IM block fill lands (IM latency + 2).
module icache_dm #(
   parameter int NUM_LINES  = 32,
   parameter int LINE_BYTES = 32
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [31:0]   Instr_address_2IC,
   input  logic          Invalidate_2IC,
   output logic [31:0]   Instr1_fIC,
   output logic [31:0]   Instr2_fIC,
   output logic          Instr1_valid_fIC,
   output logic          Instr2_valid_fIC,
   output logic          STALL_2IF,
   output logic [31:0]   Instr_address_2IM,
   output logic          iBlkRead,
   input  logic [255:0]  block_read_fIM,
   input  logic          block_read_fIM_valid
);

   localparam int IW        = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int TW        = 27 - IW;
   localparam int LINE_BITS = LINE_BYTES * 8;

   typedef enum logic {IDLE, FILL} state_t;

   state_t                state_q, state_d;
   logic [NUM_LINES-1:0]  valid_q;
   logic [TW-1:0]         tag_q  [NUM_LINES];
   logic [LINE_BITS-1:0]  data_q [NUM_LINES];

   logic [2:0]            offset;
   logic [IW-1:0]         index;
   logic [TW-1:0]         tag;
   logic [IW-1:0]         fill_index;
   logic [TW-1:0]         fill_tag;
   logic [LINE_BITS-1:0]  line;
   logic                  lookup_hit;
   logic                  start_fill;
   logic                  fill_we;
   logic                  unused_addr_lsbs;

   assign offset     = Instr_address_2IC[4:2];
   assign index      = Instr_address_2IC[4+IW:5];
   assign tag        = Instr_address_2IC[31:5+IW];
   assign fill_index = Instr_address_2IM[4+IW:5];
   assign fill_tag   = Instr_address_2IM[31:5+IW];
   assign unused_addr_lsbs = ^Instr_address_2IC[1:0];

   assign line       = data_q[index];
   assign lookup_hit = valid_q[index] && (tag_q[index] == tag);
   assign Instr1_fIC = line[{offset, 5'b0} +: 32];
   assign STALL_2IF  = ~Instr1_valid_fIC;

   always_comb begin
      state_d          = state_q;
      start_fill       = 1'b0;
      fill_we          = 1'b0;
      Instr1_valid_fIC = 1'b0;
      iBlkRead         = (state_q == FILL);
      case (state_q)
         IDLE: begin
            Instr1_valid_fIC = lookup_hit && !Invalidate_2IC && RESET;
            // A flush cycle never starts a fill; the next cycle re-looks-up and misses.
            if (!lookup_hit && !Invalidate_2IC) begin
               start_fill = 1'b1;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (Invalidate_2IC) begin
               state_d = IDLE;
            end else if (block_read_fIM_valid) begin
               fill_we = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef ICACHE_DUAL_FETCH_EN
   logic [2:0] offset_nxt;
   assign offset_nxt       = offset + 3'd1;
   assign Instr2_fIC       = line[{offset_nxt, 5'b0} +: 32];
   assign Instr2_valid_fIC = Instr1_valid_fIC && (offset != 3'd7);
`else
   assign Instr2_fIC       = 32'h0;
   assign Instr2_valid_fIC = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q           <= IDLE;
         valid_q           <= '0;
         Instr_address_2IM <= 32'h0;
      end else begin
         state_q <= state_d;
         if (start_fill) begin
            Instr_address_2IM <= {Instr_address_2IC[31:5], 5'b0};
         end
         if (Invalidate_2IC) begin
            valid_q <= '0;
         end else if (fill_we) begin
            valid_q[fill_index] <= 1'b1;
         end
      end
   end

   // Line payload needs no reset: it is only observable behind a set valid bit.
   always_ff @(posedge CLK) begin
      if (RESET && fill_we) begin
         tag_q[fill_index]  <= fill_tag;
         data_q[fill_index] <= block_read_fIM;
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: behavioural IM with a fixed block latency and a scoreboard of expected fetch words.
module tb_icache_dm;

   localparam int LAT = 3;
`ifdef ICACHE_DUAL_FETCH_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RESET;
   logic [31:0]   Instr_address_2IC;
   logic          Invalidate_2IC;
   logic [31:0]   Instr1_fIC, Instr2_fIC;
   logic          Instr1_valid_fIC, Instr2_valid_fIC, STALL_2IF;
   logic [31:0]   Instr_address_2IM;
   logic          iBlkRead;
   logic [255:0]  block_read_fIM;
   logic          block_read_fIM_valid;

   always #5 CLK = ~CLK;

   icache_dm #(.NUM_LINES(32), .LINE_BYTES(32)) dut (
      .CLK                  (CLK),
      .RESET                (RESET),
      .Instr_address_2IC    (Instr_address_2IC),
      .Invalidate_2IC       (Invalidate_2IC),
      .Instr1_fIC           (Instr1_fIC),
      .Instr2_fIC           (Instr2_fIC),
      .Instr1_valid_fIC     (Instr1_valid_fIC),
      .Instr2_valid_fIC     (Instr2_valid_fIC),
      .STALL_2IF            (STALL_2IF),
      .Instr_address_2IM    (Instr_address_2IM),
      .iBlkRead             (iBlkRead),
      .block_read_fIM       (block_read_fIM),
      .block_read_fIM_valid (block_read_fIM_valid)
   );

   typedef struct {
      logic [31:0] i1;
      logic [31:0] i2;
      logic        v2;
   } exp_t;

   int          compared   = 0;
   int          mismatched = 0;
   exp_t        sb[$];
   logic [31:0] fill_q[$];
   int          im_cnt  = 0;
   bit          im_hold = 1'b0;

   function automatic logic [31:0] mw(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [255:0] mline(input logic [31:0] a);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = mw({a[31:5], 5'b0} + 32'(4*k));
      return l;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // IM model: block valid arrives in the LAT-th consecutive cycle of iBlkRead.
   task automatic im_step();
      if (iBlkRead && !im_hold) begin
         im_cnt++;
         if (im_cnt >= LAT) begin
            block_read_fIM_valid = 1'b1;
            block_read_fIM       = mline(Instr_address_2IM);
            fill_q.push_back(Instr_address_2IM);
         end else begin
            block_read_fIM_valid = 1'b0;
         end
      end else begin
         im_cnt               = 0;
         block_read_fIM_valid = 1'b0;
      end
   endtask

   task automatic fetch(input logic [31:0] a, input int exp_stalls, input string nm);
      exp_t e;
      exp_t g;
      int   stalls = 0;
      bit   done   = 1'b0;
      e.i1 = mw(a);
      e.v2 = DUAL && (a[4:2] != 3'd7);
      e.i2 = e.v2 ? mw(a + 32'd4) : 32'h0;
      sb.push_back(e);
      Instr_address_2IC = a;
      for (int c = 0; c < 40 && !done; c++) begin
         im_step();
         #1;
         if (Instr1_valid_fIC) begin
            g = sb.pop_front();
            compared++;
            if (Instr1_fIC !== g.i1) begin
               mismatched++;
               $display("FAIL %s instr1: got %h expected %h", nm, Instr1_fIC, g.i1);
            end
            compared++;
            if (Instr2_valid_fIC !== g.v2) begin
               mismatched++;
               $display("FAIL %s instr2_valid: got %b expected %b", nm, Instr2_valid_fIC, g.v2);
            end
            if (g.v2 || !DUAL) begin
               compared++;
               if (Instr2_fIC !== g.i2) begin
                  mismatched++;
                  $display("FAIL %s instr2: got %h expected %h", nm, Instr2_fIC, g.i2);
               end
            end
            compared++;
            if (STALL_2IF !== 1'b0) begin
               mismatched++;
               $display("FAIL %s stall_on_hit: got %b expected 0", nm, STALL_2IF);
            end
            if (exp_stalls >= 0) begin
               compared++;
               if (stalls != exp_stalls) begin
                  mismatched++;
                  $display("FAIL %s miss_penalty: got %0d stall cycles expected %0d", nm, stalls, exp_stalls);
               end
            end
            done = 1'b1;
         end else begin
            stalls++;
         end
         tick();
      end
      if (!done) begin
         compared++;
         mismatched++;
         $display("FAIL %s timeout: no hit within 40 cycles, expected one", nm);
         if (sb.size() > 0) void'(sb.pop_front());
      end
   endtask

   task automatic test_reset();
      RESET = 1'b0; Invalidate_2IC = 1'b0; Instr_address_2IC = 32'h00400000;
      block_read_fIM_valid = 1'b0; block_read_fIM = '0;
      repeat (3) tick();
      compared++;
      if ({Instr1_valid_fIC, Instr2_valid_fIC, STALL_2IF, iBlkRead} !== 4'b0010) begin
         mismatched++;
         $display("FAIL reset_flags: got v1/v2/stall/rd=%b%b%b%b expected 0010",
                  Instr1_valid_fIC, Instr2_valid_fIC, STALL_2IF, iBlkRead);
      end
      compared++;
      if (Instr_address_2IM !== 32'h0) begin
         mismatched++;
         $display("FAIL reset_im_addr: got %h expected 00000000", Instr_address_2IM);
      end
      RESET = 1'b1;
   endtask

   task automatic test_miss_fill();
      fill_q.delete();
      fetch(32'h00400000, LAT + 1, "first_miss");
      compared++;
      if (fill_q.size() != 1 || fill_q[0] !== 32'h00400000) begin
         mismatched++;
         $display("FAIL fill_addr: got %0d fills first %h expected 1 fill at 00400000",
                  fill_q.size(), (fill_q.size() > 0) ? fill_q[0] : 32'hx);
      end
      compared++;
      if (iBlkRead !== 1'b0) begin
         mismatched++;
         $display("FAIL blkread_drop: got %b expected 0", iBlkRead);
      end
   endtask

   task automatic test_hits();
      for (int off = 7; off >= 0; off--) fetch(32'h00400000 + 32'(4*off), 0, "line_hit");
   endtask

   task automatic test_idle_ignore();
      Instr_address_2IC = 32'h00400000;
      for (int c = 0; c < 2; c++) begin
         block_read_fIM_valid = 1'b1;
         block_read_fIM       = ~mline(32'h00400000);
         #1;
         compared++;
         if (Instr1_valid_fIC !== 1'b1 || iBlkRead !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_ignore_state: got v1=%b rd=%b expected v1=1 rd=0", Instr1_valid_fIC, iBlkRead);
         end
         tick();
      end
      block_read_fIM_valid = 1'b0;
      fetch(32'h00400000, 0, "idle_ignore_data");
   endtask

   task automatic test_conflict();
      fetch(32'h00400400, LAT + 1, "conflict_fill");
      fetch(32'h00400000, LAT + 1, "conflict_refill");
   endtask

   task automatic test_redirect();
      fill_q.delete();
      Instr_address_2IC = 32'h00400020;
      im_step(); #1;
      compared++;
      if (Instr1_valid_fIC !== 1'b0) begin
         mismatched++;
         $display("FAIL redirect_miss: got v1=%b expected 0", Instr1_valid_fIC);
      end
      tick();
      Instr_address_2IC = 32'h00400040;
      im_step(); #1;
      compared++;
      if (iBlkRead !== 1'b1 || Instr_address_2IM !== 32'h00400020) begin
         mismatched++;
         $display("FAIL redirect_hold: got rd=%b addr=%h expected rd=1 addr=00400020", iBlkRead, Instr_address_2IM);
      end
      tick();
      fetch(32'h00400040, -1, "redirect_second");
      compared++;
      if (fill_q.size() != 2 || fill_q[0] !== 32'h00400020 || fill_q[1] !== 32'h00400040) begin
         mismatched++;
         $display("FAIL redirect_fills: got %0d fills expected 00400020 then 00400040", fill_q.size());
      end
      fetch(32'h00400020, 0, "redirect_first_line");
   endtask

   task automatic test_invalidate();
      bit seen = 1'b0;
      Instr_address_2IC = 32'h00400060;
      for (int c = 0; c < 20 && !seen; c++) begin
         im_step();
         if (block_read_fIM_valid) begin
            Invalidate_2IC = 1'b1;
            seen = 1'b1;
         end
         #1;
         tick();
      end
      Invalidate_2IC = 1'b0;
      compared++;
      if (!seen || iBlkRead !== 1'b0) begin
         mismatched++;
         $display("FAIL inval_abort: got seen=%b rd=%b expected seen=1 rd=0", seen, iBlkRead);
      end
      fetch(32'h00400060, LAT + 1, "inval_no_write");
      fetch(32'h00400020, LAT + 1, "inval_flushed");
      Instr_address_2IC = 32'h00400020;
      Invalidate_2IC    = 1'b1;
      #1;
      compared++;
      if (Instr1_valid_fIC !== 1'b0 || Instr2_valid_fIC !== 1'b0) begin
         mismatched++;
         $display("FAIL inval_mask: got v1=%b v2=%b expected 0 0", Instr1_valid_fIC, Instr2_valid_fIC);
      end
      tick();
      Invalidate_2IC = 1'b0;
      fetch(32'h00400020, LAT + 1, "inval_on_hit");
   endtask

   task automatic test_reset_mid_fill();
      Instr_address_2IC = 32'h00400080;
      im_step(); #1;
      tick();
      im_hold = 1'b1;
      im_step(); #1;
      compared++;
      if (iBlkRead !== 1'b1) begin
         mismatched++;
         $display("FAIL rst_fill_entry: got rd=%b expected 1", iBlkRead);
      end
      RESET = 1'b0;
      tick();
      compared++;
      if (iBlkRead !== 1'b0 || Instr1_valid_fIC !== 1'b0 || STALL_2IF !== 1'b1 || Instr_address_2IM !== 32'h0) begin
         mismatched++;
         $display("FAIL rst_mid_fill: got rd=%b v1=%b stall=%b addr=%h expected 0 0 1 00000000",
                  iBlkRead, Instr1_valid_fIC, STALL_2IF, Instr_address_2IM);
      end
      RESET   = 1'b1;
      im_hold = 1'b0;
      fetch(32'h00400020, LAT + 1, "rst_lost_line");
      fetch(32'h00400080, LAT + 1, "rst_refetch");
   endtask

   initial begin
      test_reset();
      test_miss_fill();
      test_hits();
      test_idle_ignore();
      test_conflict();
      test_redirect();
      test_invalidate();
      test_reset_mid_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
